// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, control-flow opcodes and the
// branch controller state encoding.
package cpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] JUMP_OP = 6'b010101;
  localparam logic [5:0] BRA_OP  = 6'b010110;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPND,
    RESOLVE,
    REDIRECT
  } state_t;

endpackage

// File: rtl/branch_target_unit.sv
// Redirect target generation: PC-relative add for BRA, absolute immediate
// for JUMP (and any other opcode, which never reaches a redirect).
module branch_target_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] pc_delay,
  input  logic [DATA_W-1:0] immediate_value_sign,
  output logic [DATA_W-1:0] target
);
  import cpu_pkg::*;

  // The add is modulo 2^DATA_W; a carry out of the top bit is dropped.
  always_comb begin
    target = immediate_value_sign;
    if (opcode == BRA_OP) begin
      target = pc_delay + immediate_value_sign;
    end
  end

endmodule

// File: rtl/branch_controller.sv
// Branch/jump resolution: stalls fetch while operands arrive from the
// multi-cycle register file, compares them, then redirects and flushes.
module branch_controller #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int MAX_WAIT = 7,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] pc_delay,
  input  logic [DATA_W-1:0] immediate_value_sign,
  input  logic [DATA_W-1:0] rs1_value,
  input  logic [DATA_W-1:0] rs2_value,
  input  logic              rf_rd_valid,
  output logic [DATA_W-1:0] pc_next,
  output logic              pc_load,
  output logic              branch_taken,
  output logic              stall,
  output logic              flush,
  output logic              busy,
  output logic              rf_timeout
);
  import cpu_pkg::*;

  state_t            r_state;
  logic [5:0]        r_opcode;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_rs1;
  logic [DATA_W-1:0] r_rs2;
  logic [DATA_W-1:0] r_pc_hold;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_redirect;
  logic              r_timeout;

  logic [DATA_W-1:0] w_target;
  logic              w_recognised;
  logic              w_capture;

  assign w_recognised = (opcode == JUMP_OP) || (opcode == BRA_OP);
  assign w_capture    = rst_n && instr_valid && w_recognised && (r_state == IDLE);

  branch_target_unit #(
    .DATA_W(DATA_W)
  ) u_target (
    .opcode               (r_opcode),
    .pc_delay             (r_pc),
    .immediate_value_sign (r_imm),
    .target               (w_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_opcode   <= '0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_pc_hold  <= '0;
      r_cnt      <= '0;
      r_redirect <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_opcode <= opcode;
            r_pc     <= pc_delay;
            r_imm    <= immediate_value_sign;
            r_cnt    <= '0;
            if (opcode == JUMP_OP) begin
              r_state    <= REDIRECT;
              r_redirect <= 1'b1;
            end else begin
              r_state <= WAIT_OPND;
            end
          end
        end
        // Operand arrival wins over the timeout on the final wait cycle.
        WAIT_OPND: begin
          if (rf_rd_valid) begin
            r_rs1   <= rs1_value;
            r_rs2   <= rs2_value;
            r_state <= RESOLVE;
          end else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
            r_cnt     <= CNT_W'(MAX_WAIT);
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESOLVE: begin
          if (r_rs1 == r_rs2) begin
            r_state    <= REDIRECT;
            r_redirect <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        REDIRECT: begin
          r_pc_hold <= w_target;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The target is live during REDIRECT and held afterwards until the next one.
  assign pc_next      = (r_state == REDIRECT) ? w_target : r_pc_hold;
  assign pc_load      = r_redirect;
  assign branch_taken = r_redirect;
  assign flush        = r_redirect;
  assign busy         = (r_state != IDLE);
  assign stall        = busy || w_capture;
  assign rf_timeout   = r_timeout;

endmodule

// File: tb/tb_branch_controller.sv
// Randomised self-checking bench for branch_controller against a
// cycle-count reference model of branch/jump resolution.
module tb_branch_controller;

  localparam int         MAX_WAIT = 7;
  localparam logic [5:0] JMP      = 6'b010101;
  localparam logic [5:0] BRA      = 6'b010110;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [31:0] pc_delay;
  logic [31:0] immediate_value_sign;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        rf_rd_valid;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        branch_taken;
  logic        stall;
  logic        flush;
  logic        busy;
  logic        rf_timeout;

  int checks = 0;
  int passes = 0;

  int          obs_load_cycle;
  int          obs_load_cnt;
  logic [31:0] obs_pc_next;
  int          obs_flag_bad;
  int          obs_stall_bad;
  int          obs_busy_bad;
  logic        obs_tail_stall;
  logic        obs_tail_busy;
  logic [31:0] obs_tail_pc_next;

  logic [31:0] exp_last_target;
  logic        exp_timeout;

  branch_controller #(
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (3)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .instr_valid          (instr_valid),
    .opcode               (opcode),
    .pc_delay             (pc_delay),
    .immediate_value_sign (immediate_value_sign),
    .rs1_value            (rs1_value),
    .rs2_value            (rs2_value),
    .rf_rd_valid          (rf_rd_valid),
    .pc_next              (pc_next),
    .pc_load              (pc_load),
    .branch_taken         (branch_taken),
    .stall                (stall),
    .flush                (flush),
    .busy                 (busy),
    .rf_timeout           (rf_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycle offsets relative to the capture cycle (0).
  function automatic int model_end(input logic [5:0] op, input int k, input bit eq);
    if (op == JMP) return 2;
    if (k < 1 || k > MAX_WAIT) return MAX_WAIT + 1;
    return eq ? k + 3 : k + 2;
  endfunction

  function automatic int model_load(input logic [5:0] op, input int k, input bit eq);
    if (op == JMP) return 1;
    if (k >= 1 && k <= MAX_WAIT && eq) return k + 2;
    return -1;
  endfunction

  function automatic logic [31:0] model_target(input logic [5:0] op, input logic [31:0] pc,
                                               input logic [31:0] imm);
    return (op == BRA) ? pc + imm : imm;
  endfunction

  // Drives one instruction (capture at cycle 0, operands at cycle k) and
  // records what the DUT did; junk instructions are offered while busy.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input int k, input logic [31:0] rs1, input logic [31:0] rs2,
                         input bit tail);
    int e;
    int ld;
    e = model_end(op, k, rs1 == rs2);
    ld = model_load(op, k, rs1 == rs2);
    obs_load_cycle = -1;
    obs_load_cnt   = 0;
    obs_pc_next    = '0;
    obs_flag_bad   = 0;
    obs_stall_bad  = 0;
    obs_busy_bad   = 0;
    for (int c = 0; c < e; c++) begin
      @(negedge clk);
      instr_valid = 1'b1;
      if (c == 0) begin
        opcode               = op;
        pc_delay             = pc;
        immediate_value_sign = imm;
      end else begin
        opcode               = ($urandom_range(0, 1) != 0) ? JMP : BRA;
        pc_delay             = $urandom;
        immediate_value_sign = $urandom;
      end
      rf_rd_valid = (c == k);
      rs1_value   = (c == k) ? rs1 : $urandom;
      rs2_value   = (c == k) ? rs2 : $urandom;
      #2;
      if (stall !== 1'b1) obs_stall_bad++;
      if (busy !== (c != 0)) obs_busy_bad++;
      if (pc_load === 1'b1) begin
        obs_load_cnt++;
        obs_load_cycle = c;
        obs_pc_next    = pc_next;
      end
      if (flush !== pc_load || branch_taken !== pc_load) obs_flag_bad++;
    end
    if (ld >= 0) exp_last_target = model_target(op, pc, imm);
    if (op == BRA && (k < 1 || k > MAX_WAIT)) exp_timeout = 1'b1;
    if (tail) begin
      @(negedge clk);
      instr_valid = 1'b0;
      rf_rd_valid = 1'b0;
      opcode      = ($urandom_range(0, 1) != 0) ? JMP : BRA;
      #2;
      obs_tail_stall   = stall;
      obs_tail_busy    = busy;
      obs_tail_pc_next = pc_next;
      if (pc_load === 1'b1) obs_load_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_valid = 1'b1;
    opcode = JMP;
    pc_delay = 32'h100;
    immediate_value_sign = 32'h400;
    rs1_value = '0;
    rs2_value = '0;
    rf_rd_valid = 1'b0;
    exp_last_target = '0;
    exp_timeout = 1'b0;
    #12;
    checks++;
    if ({pc_load, branch_taken, stall, flush, busy, rf_timeout} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %b want 000000",
               {pc_load, branch_taken, stall, flush, busy, rf_timeout});
    else passes++;
    checks++;
    if (pc_next !== 32'h0) $display("[TB] FAIL reset_pc_next: got %h want 0", pc_next);
    else passes++;
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_jump();
    run_txn(JMP, 32'h100, 32'h0000_0400, 0, '0, '0, 1'b1);
    checks++;
    if (obs_load_cycle !== 1 || obs_load_cnt !== 1)
      $display("[TB] FAIL jump_load: got cycle %0d count %0d want cycle 1 count 1", obs_load_cycle, obs_load_cnt);
    else passes++;
    checks++;
    if (obs_pc_next !== 32'h400) $display("[TB] FAIL jump_pc_next: got %h want 00000400", obs_pc_next);
    else passes++;
    checks++;
    if (obs_stall_bad != 0 || obs_tail_stall !== 1'b0 || obs_flag_bad != 0)
      $display("[TB] FAIL jump_stall_flush: got stall_bad %0d tail_stall %b flag_bad %0d want 0 0 0",
               obs_stall_bad, obs_tail_stall, obs_flag_bad);
    else passes++;
  endtask

  task automatic test_bra_taken();
    run_txn(BRA, 32'h200, 32'hFFFF_FFF0, 3, 32'h55, 32'h55, 1'b1);
    checks++;
    if (obs_load_cycle !== 5 || obs_load_cnt !== 1)
      $display("[TB] FAIL bra_taken_load: got cycle %0d count %0d want cycle 5 count 1", obs_load_cycle, obs_load_cnt);
    else passes++;
    checks++;
    if (obs_pc_next !== 32'h1F0) $display("[TB] FAIL bra_taken_pc_next: got %h want 000001f0", obs_pc_next);
    else passes++;
    checks++;
    if (obs_busy_bad != 0 || obs_flag_bad != 0 || obs_tail_busy !== 1'b0)
      $display("[TB] FAIL bra_taken_busy: got busy_bad %0d flag_bad %0d tail_busy %b want 0 0 0",
               obs_busy_bad, obs_flag_bad, obs_tail_busy);
    else passes++;
  endtask

  task automatic test_bra_not_taken();
    run_txn(BRA, 32'h300, 32'h40, 1, 32'h1, 32'h2, 1'b1);
    checks++;
    if (obs_load_cnt !== 0) $display("[TB] FAIL bra_nt_no_load: got %0d loads want 0", obs_load_cnt);
    else passes++;
    checks++;
    if (obs_busy_bad != 0 || obs_tail_busy !== 1'b0 || obs_tail_stall !== 1'b0)
      $display("[TB] FAIL bra_nt_release: got busy_bad %0d tail_busy %b tail_stall %b want 0 0 0",
               obs_busy_bad, obs_tail_busy, obs_tail_stall);
    else passes++;
    checks++;
    if (obs_tail_pc_next !== 32'h1F0) $display("[TB] FAIL bra_nt_pc_hold: got %h want 000001f0", obs_tail_pc_next);
    else passes++;
  endtask

  task automatic test_wrap();
    run_txn(BRA, 32'hFFFF_FFF8, 32'h10, 2, 32'hDEAD, 32'hDEAD, 1'b1);
    checks++;
    if (obs_load_cycle !== 4 || obs_pc_next !== 32'h8)
      $display("[TB] FAIL wrap_target: got cycle %0d pc %h want cycle 4 pc 00000008", obs_load_cycle, obs_pc_next);
    else passes++;
  endtask

  task automatic test_back_to_back();
    run_txn(JMP, 32'h0, 32'h1234, 0, '0, '0, 1'b0);
    checks++;
    if (obs_load_cycle !== 1 || obs_pc_next !== 32'h1234)
      $display("[TB] FAIL b2b_first: got cycle %0d pc %h want cycle 1 pc 00001234", obs_load_cycle, obs_pc_next);
    else passes++;
    run_txn(JMP, 32'h0, 32'h5678, 0, '0, '0, 1'b1);
    checks++;
    if (obs_load_cycle !== 1 || obs_pc_next !== 32'h5678 || obs_stall_bad != 0)
      $display("[TB] FAIL b2b_second: got cycle %0d pc %h stall_bad %0d want 1 00005678 0",
               obs_load_cycle, obs_pc_next, obs_stall_bad);
    else passes++;
  endtask

  task automatic test_limit_valid();
    run_txn(BRA, 32'h1000, 32'h20, MAX_WAIT, 32'h7, 32'h7, 1'b1);
    checks++;
    if (obs_load_cycle !== MAX_WAIT + 2 || obs_pc_next !== 32'h1020)
      $display("[TB] FAIL limit_valid: got cycle %0d pc %h want cycle %0d pc 00001020",
               obs_load_cycle, obs_pc_next, MAX_WAIT + 2);
    else passes++;
    checks++;
    if (rf_timeout !== 1'b0) $display("[TB] FAIL limit_no_timeout: got %b want 0", rf_timeout);
    else passes++;
  endtask

  task automatic test_timeout();
    run_txn(BRA, 32'h2000, 32'h30, 0, 32'h3, 32'h3, 1'b1);
    checks++;
    if (obs_load_cnt !== 0 || obs_stall_bad != 0 || obs_tail_stall !== 1'b0)
      $display("[TB] FAIL timeout_release: got loads %0d stall_bad %0d tail_stall %b want 0 0 0",
               obs_load_cnt, obs_stall_bad, obs_tail_stall);
    else passes++;
    checks++;
    if (rf_timeout !== 1'b1) $display("[TB] FAIL timeout_flag: got %b want 1", rf_timeout);
    else passes++;
    run_txn(JMP, 32'h0, 32'h44, 0, '0, '0, 1'b1);
    checks++;
    if (rf_timeout !== 1'b1 || obs_pc_next !== 32'h44)
      $display("[TB] FAIL timeout_sticky: got flag %b pc %h want 1 00000044", rf_timeout, obs_pc_next);
    else passes++;
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    bit          tail;
    for (int n = 0; n < 24; n++) begin
      op   = ($urandom_range(0, 2) == 0) ? JMP : BRA;
      pc   = $urandom;
      imm  = $urandom;
      a    = $urandom;
      b    = ($urandom_range(0, 1) != 0) ? a : $urandom;
      k    = $urandom_range(1, MAX_WAIT + 1);
      tail = ($urandom_range(0, 1) != 0);
      run_txn(op, pc, imm, k, a, b, tail);
      checks++;
      if (obs_load_cycle !== model_load(op, k, a == b))
        $display("[TB] FAIL rand_load_cycle[%0d]: got %0d want %0d", n, obs_load_cycle, model_load(op, k, a == b));
      else passes++;
      if (model_load(op, k, a == b) >= 0) begin
        checks++;
        if (obs_pc_next !== model_target(op, pc, imm))
          $display("[TB] FAIL rand_pc_next[%0d]: got %h want %h", n, obs_pc_next, model_target(op, pc, imm));
        else passes++;
      end
      checks++;
      if (obs_stall_bad != 0 || obs_busy_bad != 0 || obs_flag_bad != 0)
        $display("[TB] FAIL rand_ctrl[%0d]: got stall_bad %0d busy_bad %0d flag_bad %0d want 0 0 0",
                 n, obs_stall_bad, obs_busy_bad, obs_flag_bad);
      else passes++;
      if (tail) begin
        checks++;
        if (obs_tail_stall !== 1'b0 || obs_tail_pc_next !== exp_last_target || rf_timeout !== exp_timeout)
          $display("[TB] FAIL rand_idle[%0d]: got stall %b pc %h timeout %b want 0 %h %b",
                   n, obs_tail_stall, obs_tail_pc_next, rf_timeout, exp_last_target, exp_timeout);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    instr_valid = 1'b1;
    opcode = BRA;
    pc_delay = 32'h4000;
    immediate_value_sign = 32'h8;
    rf_rd_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      instr_valid = 1'b0;
    end
    #2;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL midrst_busy_before: got %b want 1", busy);
    else passes++;
    rst_n = 1'b0;
    #1;
    exp_last_target = '0;
    exp_timeout = 1'b0;
    checks++;
    if ({pc_load, branch_taken, stall, flush, busy, rf_timeout} !== 6'b0 || pc_next !== 32'h0)
      $display("[TB] FAIL midrst_outputs: got flags %b pc %h want 000000 00000000",
               {pc_load, branch_taken, stall, flush, busy, rf_timeout}, pc_next);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    instr_valid = 1'b1;
    opcode = 6'b000001;
    #2;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL ignored_op_stall: got %b want 0", stall);
    else passes++;
    @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || pc_load !== 1'b0)
      $display("[TB] FAIL ignored_op_idle: got busy %b stall %b load %b want 0 0 0", busy, stall, pc_load);
    else passes++;
    instr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_jump();
    test_bra_taken();
    test_bra_not_taken();
    test_wrap();
    test_back_to_back();
    test_limit_valid();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
